// File: rtl/nf_cf_bank_if.sv
// nf_cf_bank_if: bus between a driver and the null-fresh quadratic component-function bank
//   en        pipeline advance (0 = stall)
//   flush     valid-clear, only acts while en=1
//   in_valid  a/b/c/d carry a valid sharing
//   a,b,c,d   3 shares per channel, bit ch*3+(s-1) = share s of channel ch
//   y0,y1     OUT_SH shares per channel, bit ch*OUT_SH+k = share k of channel ch
//   out_valid y0/y1 hold a valid sharing
interface nf_cf_bank_if #(
    parameter int NUM_CH   = 16,
    parameter int COMPRESS = 1
);
    localparam int OUT_SH = (COMPRESS != 0) ? 3 : 9;
    logic                     en;
    logic                     flush;
    logic                     in_valid;
    logic [3*NUM_CH-1:0]      a;
    logic [3*NUM_CH-1:0]      b;
    logic [3*NUM_CH-1:0]      c;
    logic [3*NUM_CH-1:0]      d;
    logic [OUT_SH*NUM_CH-1:0] y0;
    logic [OUT_SH*NUM_CH-1:0] y1;
    logic                     out_valid;
    modport master (output en, flush, in_valid, a, b, c, d, input y0, y1, out_valid);
    modport slave  (input en, flush, in_valid, a, b, c, d, output y0, y1, out_valid);
endinterface

// File: rtl/nf_cf_bank.sv
// nf_cf_bank: channel-parallel 3-share null-fresh quadratic component functions
//   y0 = d&c ^ b and y1 = a ^ b ^ d&c ^ d&b, 9 cross-share terms registered per channel,
//   optionally compressed to 3 shares in a second registered stage.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all data and valid registers
//   bus    nf_cf_bank_if slave: en/flush/in_valid/a/b/c/d in, y0/y1/out_valid out
module nf_cf_bank #(
    parameter int NUM_CH   = 16,
    parameter int COMPRESS = 1
) (
    input logic        clk,
    input logic        rst_n,
    nf_cf_bank_if.slave bus
);
    localparam int TW = 9 * NUM_CH;

    // Row i of the 3x3 term grid sits at bits i*3+:3, column j inside the row.
    // Each term carries its own linear share so that every output share stays
    // non-complete; the linear parts were chosen to sum to b (y0) and a^b (y1).
    function automatic logic [17:0] cf_terms(input logic [2:0] a, input logic [2:0] b,
                                             input logic [2:0] c, input logic [2:0] d);
        logic [8:0] dc, db, l0, l1;
        dc = {{3{d[2]}} & c, {3{d[1]}} & c, {3{d[0]}} & c};
        db = {{3{d[2]}} & b, {3{d[1]}} & b, {3{d[0]}} & b};
        l0 = {c[2], 1'b0, b[0], b[1], 1'b0, c[0], d[0] ^ c[2] ^ b[2], 1'b0, d[0] ^ c[0]};
        l1 = {d[2] ^ c[2] ^ b[2], d[2], a[2] ^ b[0], d[1] ^ c[2] ^ b[2], c[1],
              a[1] ^ d[1], b[2], c[1] ^ b[1], a[0]};
        return {dc ^ db ^ l1, dc ^ l0};
    endfunction

    logic [TW-1:0] t0_d, t1_d, t0_q, t1_q;
    logic          v1_q;

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            assign {t1_d[n*9+:9], t0_d[n*9+:9]} =
                cf_terms(bus.a[n*3+:3], bus.b[n*3+:3], bus.c[n*3+:3], bus.d[n*3+:3]);
        end
    endgenerate

    // Glitch barrier: every term is registered on its own before any recombination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0_q <= '0;
            t1_q <= '0;
            v1_q <= 1'b0;
        end else if (bus.en) begin
            t0_q <= t0_d;
            t1_q <= t1_d;
            v1_q <= bus.in_valid & ~bus.flush;
        end
    end

    generate
        if (COMPRESS != 0) begin : g_cmp
            logic [3*NUM_CH-1:0] y0_d, y1_d, y0_q, y1_q;
            logic                v2_q;
            for (n = 0; n < NUM_CH; n++) begin : g_ch
                // Output share i folds row i of the grid (terms (i,1),(i,2),(i,3)).
                assign y0_d[n*3+:3] = {^t0_q[n*9+6+:3], ^t0_q[n*9+3+:3], ^t0_q[n*9+:3]};
                assign y1_d[n*3+:3] = {^t1_q[n*9+6+:3], ^t1_q[n*9+3+:3], ^t1_q[n*9+:3]};
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y0_q <= '0;
                    y1_q <= '0;
                    v2_q <= 1'b0;
                end else if (bus.en) begin
                    y0_q <= y0_d;
                    y1_q <= y1_d;
                    v2_q <= v1_q & ~bus.flush;
                end
            end
            assign bus.y0        = y0_q;
            assign bus.y1        = y1_q;
            assign bus.out_valid = v2_q;
        end else begin : g_raw
            assign bus.y0        = t0_q;
            assign bus.y1        = t1_q;
            assign bus.out_valid = v1_q;
        end
    endgenerate
endmodule

// File: tb/tb_nf_cf_bank.sv
// tb_nf_cf_bank: randomized check of nf_cf_bank against an unshared reference model
//   Instance A: COMPRESS=1, NUM_CH=1 (2-stage); instance B: COMPRESS=0, NUM_CH=16 (1-stage).
module tb_nf_cf_bank;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nf_cf_bank_if #(.NUM_CH(1),  .COMPRESS(1)) ia ();
    nf_cf_bank_if #(.NUM_CH(16), .COMPRESS(0)) ib ();

    nf_cf_bank #(.NUM_CH(1),  .COMPRESS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    nf_cf_bank #(.NUM_CH(16), .COMPRESS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    typedef struct packed {
        logic        v;
        logic [15:0] e0;
        logic [15:0] e1;
    } ent_t;

    ent_t pa [2];
    ent_t pb;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Unshared truth: recombine each channel's shares, then apply the Boolean functions.
    function automatic logic [31:0] ref_y(input logic [47:0] a, input logic [47:0] b,
                                          input logic [47:0] c, input logic [47:0] d);
        logic [15:0] e0, e1;
        logic ua, ub, uc, ud;
        for (int ch = 0; ch < 16; ch++) begin
            ua = ^a[ch*3+:3];
            ub = ^b[ch*3+:3];
            uc = ^c[ch*3+:3];
            ud = ^d[ch*3+:3];
            e0[ch] = (ud & uc) ^ ub;
            e1[ch] = ua ^ ub ^ (ud & uc) ^ (ud & ub);
        end
        return {e1, e0};
    endfunction

    function automatic logic [15:0] fold(input logic [143:0] y, input int sh);
        logic [15:0] r = '0;
        for (int ch = 0; ch < 16; ch++)
            for (int k = 0; k < sh; k++)
                r[ch] = r[ch] ^ y[ch*sh+k];
        return r;
    endfunction

    task automatic reset_model();
        pa[0] = '0;
        pa[1] = '0;
        pb    = '0;
    endtask

    task automatic tick_a();
        logic [31:0] r;
        @(posedge clk);
        r = ref_y(48'(ia.a), 48'(ia.b), 48'(ia.c), 48'(ia.d));
        if (ia.en) begin
            pa[1] = pa[0];
            pa[0] = '{v: ia.in_valid, e0: r[15:0], e1: r[31:16]};
            if (ia.flush) begin
                pa[0].v = 1'b0;
                pa[1].v = 1'b0;
            end
        end
        #1;
        chk("a_valid", 144'(ia.out_valid), 144'(pa[1].v));
        chk("a_y0", 144'(fold(144'(ia.y0), 3)), 144'(pa[1].e0));
        chk("a_y1", 144'(fold(144'(ia.y1), 3)), 144'(pa[1].e1));
    endtask

    task automatic tick_b();
        logic [31:0] r;
        @(posedge clk);
        r = ref_y(ib.a, ib.b, ib.c, ib.d);
        if (ib.en)
            pb = '{v: ib.in_valid & ~ib.flush, e0: r[15:0], e1: r[31:16]};
        #1;
        chk("b_valid", 144'(ib.out_valid), 144'(pb.v));
        chk("b_y0", 144'(fold(ib.y0, 9)), 144'(pb.e0));
        chk("b_y1", 144'(fold(ib.y1, 9)), 144'(pb.e1));
    endtask

    initial begin
        {ia.en, ia.flush, ia.in_valid, ia.a, ia.b, ia.c, ia.d} = '0;
        {ib.en, ib.flush, ib.in_valid, ib.a, ib.b, ib.c, ib.d} = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 144'(ia.out_valid), 144'(0));
        chk("rst_a_y", 144'({ia.y0, ia.y1}), 144'(0));
        chk("rst_b_valid", 144'(ib.out_valid), 144'(0));
        chk("rst_b_y", {ib.y0 | ib.y1}, 144'(0));
        rst_n = 1'b1;

        // Reference sharing from the function example: a=1,b=0,c=0,d=1.
        ia.en = 1'b1;
        ia.in_valid = 1'b1;
        ia.a = 3'b001;
        ia.b = 3'b011;
        ia.c = 3'b110;
        ia.d = 3'b111;
        tick_a();
        ia.in_valid = 1'b0;
        tick_a();
        chk("ex_valid", 144'(ia.out_valid), 144'(1));
        chk("ex_y0", 144'(^ia.y0), 144'(0));
        chk("ex_y1", 144'(^ia.y1), 144'(1));

        // Stall: item into stage 1, then 5 stalled cycles (one with flush asserted).
        ia.in_valid = 1'b1;
        {ia.d, ia.c, ia.b, ia.a} = 12'($urandom);
        tick_a();
        ia.in_valid = 1'b0;
        ia.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ia.flush = (k == 2);
            {ia.d, ia.c, ia.b, ia.a} = 12'($urandom);
            tick_a();
            chk("stall_hold", 144'(ia.out_valid), 144'(0));
        end
        ia.flush = 1'b0;
        ia.en = 1'b1;
        tick_a();
        chk("stall_emerge", 144'(ia.out_valid), 144'(1));

        // Flush on the 2nd of three back-to-back items.
        ia.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ia.flush = (k == 1);
            {ia.d, ia.c, ia.b, ia.a} = 12'($urandom);
            tick_a();
        end
        ia.flush = 1'b0;
        chk("flush_drop", 144'(ia.out_valid), 144'(0));
        ia.in_valid = 1'b0;
        tick_a();
        chk("flush_item3", 144'(ia.out_valid), 144'(1));

        // Exhaustive share combinations with random stalls and rare flushes.
        for (int v = 0; v < 4096; v++) begin
            {ia.d, ia.c, ia.b, ia.a} = 12'(v);
            ia.in_valid = 1'($urandom);
            ia.en = ($urandom_range(0, 7) != 0);
            ia.flush = ($urandom_range(0, 63) == 0);
            tick_a();
        end
        ia.en = 1'b0;
        ia.flush = 1'b0;

        // Wide, single-stage streaming.
        for (int i = 0; i < 10000; i++) begin
            ib.en = ($urandom_range(0, 9) != 0);
            ib.in_valid = 1'($urandom);
            ib.flush = ($urandom_range(0, 31) == 0);
            ib.a = {16'($urandom), $urandom};
            ib.b = {16'($urandom), $urandom};
            ib.c = {16'($urandom), $urandom};
            ib.d = {16'($urandom), $urandom};
            tick_b();
        end

        // Channel isolation: only one channel's shares change per cycle.
        ib.en = 1'b1;
        ib.flush = 1'b0;
        ib.in_valid = 1'b1;
        for (int ch = 0; ch < 16; ch++)
            for (int k = 0; k < 4; k++) begin
                ib.a[ch*3+:3] = 3'($urandom);
                ib.b[ch*3+:3] = 3'($urandom);
                ib.c[ch*3+:3] = 3'($urandom);
                ib.d[ch*3+:3] = 3'($urandom);
                tick_b();
            end
        chk("pre_rst_valid", 144'(ib.out_valid), 144'(1));

        // Asynchronous reset mid-stream, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_b_valid", 144'(ib.out_valid), 144'(0));
        chk("async_b_y", {ib.y0 | ib.y1}, 144'(0));
        chk("async_a_valid", 144'(ia.out_valid), 144'(0));
        chk("async_a_y", 144'({ia.y0, ia.y1}), 144'(0));
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        ib.in_valid = 1'b0;
        tick_b();
        chk("post_rst_valid", 144'(ib.out_valid), 144'(0));
        ib.in_valid = 1'b1;
        tick_b();
        chk("post_rst_item", 144'(ib.out_valid), 144'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
